// File: rtl/clk_gate_sync.sv
// Reset-clearing flop chain that brings the functional enable onto the clk
// domain before it reaches the gating latch.
`timescale 1ns/1ps

module clk_gate_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_gate.sv
// Glitch-free clock-gating cell: low-transparent enable latch ANDed with the
// source clock, with optional enable synchroniser and scan bypass.
`timescale 1ns/1ps

module clk_gate #(
  parameter int EN_SYNC_STAGES    = 0,
  parameter int RESET_GATED_VALUE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic test_en,
  output logic gated,
  output logic en_active
);

  localparam int MinSyncStages = 0;
  localparam int MaxSyncStages = 4;

  if ((EN_SYNC_STAGES < MinSyncStages) || (EN_SYNC_STAGES > MaxSyncStages)) begin : g_bad_stages
    $error("clk_gate: EN_SYNC_STAGES must be within 0..4");
  end

  if (RESET_GATED_VALUE != 0) begin : g_bad_reset_value
    $error("clk_gate: RESET_GATED_VALUE other than 0 is not supported");
  end

  logic en_sync;
  logic en_eff;
  logic en_lat_q;

  if (EN_SYNC_STAGES > 0) begin : g_sync
    clk_gate_sync #(
      .STAGES (EN_SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (en),
      .q_o   (en_sync)
    );
  end else begin : g_nosync
    assign en_sync = en;
  end

  assign en_eff = en_sync | test_en;

  // Latch + AND below are to be swapped for the library ICG cell at synthesis.
  always_latch begin
    if (!rst_n) begin
      en_lat_q = 1'b0;
    end else if (!clk) begin
      en_lat_q = en_eff;
    end
  end

  assign gated     = clk & en_lat_q;
  assign en_active = en_lat_q;

endmodule

// File: tb/tb_clk_gate.sv
// Scoreboard bench for clk_gate: one instance without and one with a
// two-stage enable synchroniser, driven from shared inputs.
`timescale 1ns/1ps

module tb_clk_gate;

  typedef struct packed {
    logic g0;
    logic g2;
  } ScoreEntry;

  logic clk;
  logic rst_n;
  logic en;
  logic test_en;
  logic gated0;
  logic enActive0;
  logic gated2;
  logic enActive2;

  int totalCount = 0;
  int badCount   = 0;

  ScoreEntry sbQ[$];

  // Reference model of the two-stage synchroniser.
  logic s1;
  logic s2;

  time rise0;
  time rise2;

  clk_gate #(
    .EN_SYNC_STAGES    (0),
    .RESET_GATED_VALUE (0)
  ) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .test_en   (test_en),
    .gated     (gated0),
    .en_active (enActive0)
  );

  clk_gate #(
    .EN_SYNC_STAGES    (2),
    .RESET_GATED_VALUE (0)
  ) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .test_en   (test_en),
    .gated     (gated2),
    .en_active (enActive2)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    if (obs !== exp) begin
      badCount++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Any gated high pulse outside reset must span a full 50 ns high phase.
  always @(posedge gated0) rise0 = $time;
  always @(negedge gated0) begin
    if (rst_n === 1'b1) checkOutput("pulseWidth0", 32'(($time - rise0) >= 50), 1);
  end
  always @(posedge gated2) rise2 = $time;
  always @(negedge gated2) begin
    if (rst_n === 1'b1) checkOutput("pulseWidth2", 32'(($time - rise2) >= 50), 1);
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic newEn, input logic newTen, input int midMode);
    ScoreEntry e;
    ScoreEntry got;
    #1;
    checkOutput("lowGated0", gated0, 0);
    checkOutput("lowGated2", gated2, 0);
    #9;
    en      = 1'($urandom_range(0, 1));
    test_en = 1'($urandom_range(0, 1));
    #10;
    en      = newEn;
    test_en = newTen;
    e.g0 = rst_n & (newEn | newTen);
    e.g2 = rst_n & (s2 | newTen);
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checkOutput("sbEmpty", 1, 0);
    end else begin
      got = sbQ.pop_front();
      checkOutput("gated0", gated0, got.g0);
      checkOutput("enActive0", enActive0, got.g0);
      checkOutput("gated2", gated2, got.g2);
      checkOutput("enActive2", enActive2, got.g2);
      if (rst_n) begin
        s2 = s1;
        s1 = newEn;
      end
      if (midMode == 1) begin
        #9 en = 1'bx;
        #20;
        checkOutput("xHold0", gated0, got.g0);
        checkOutput("xHold2", gated2, got.g2);
        #10 en = newEn;
      end else if (midMode == 2) begin
        #9 en = ~newEn;
        #20;
        checkOutput("midHold0", gated0, got.g0);
        checkOutput("midHold2", gated2, got.g2);
      end
    end
    @(negedge clk);
  endtask

  // Reset asserted and released mid high phase; starts and ends at a falling edge.
  task automatic applyResetMidHigh();
    @(posedge clk);
    #25 rst_n = 1'b0;
    #1;
    checkOutput("rstGated0", gated0, 0);
    checkOutput("rstActive0", enActive0, 0);
    checkOutput("rstGated2", gated2, 0);
    checkOutput("rstActive2", enActive2, 0);
    s1 = 1'b0;
    s2 = 1'b0;
    @(posedge clk);
    #25 rst_n = 1'b1;
    #1;
    checkOutput("relGated0", gated0, 0);
    checkOutput("relGated2", gated2, 0);
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    test_en = 1'b0;
    s1      = 1'b0;
    s2      = 1'b0;
    rise0   = 0;
    rise2   = 0;

    #60;
    checkOutput("resetGated0", gated0, 0);
    checkOutput("resetActive0", enActive0, 0);
    checkOutput("resetGated2", gated2, 0);
    checkOutput("resetActive2", enActive2, 0);

    #60 rst_n = 1'b1;
    #1;
    checkOutput("releaseActive0", enActive0, 1);
    checkOutput("releaseActive2", enActive2, 0);
    @(posedge clk);
    s2 = s1;
    s1 = en;
    #1;
    checkOutput("firstEdge0", gated0, 1);
    checkOutput("firstEdge2", gated2, 0);
    @(negedge clk);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, (i == 2) ? 1 : 0);
    applyStimulus(1'b1, 1'b0, 2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0);
    applyResetMidHigh();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 0);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                    int'($urandom_range(0, 2)));
    end

    checkOutput("queueDrained", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
